wired_bpu_upd_sched: RTL and testbench
======================================

Name: wired_bpu_upd_sched

Overview:
Scheduler between the two commit lanes and the PC-gen predictor correction port (bpu_correct_t).
- Merges up to two correction packets per cycle into one per-cycle registered update stream.
- Urgent packets (redirect / miss / RAS-type miss) take priority; training-only updates are buffered in a small FIFO.
- After reset or a predictor flush, a clear sequencer sweeps the BTB/info/L2 tables before training resumes.

Parameters:
DEPTH, 4, training FIFO entries (power of two, >=2).
INIT_DEPTH, 512, number of table indices swept by the clear sequencer.
INIT_AW, 9, width of init_addr_o; must satisfy 2^INIT_AW >= INIT_DEPTH.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
c_valid_i  in  2  per-lane packet valid, lane 0 older.
c_correct_i  in  2 x bpu_correct_t  per-lane correction packet.
flush_i  in  1  predictor invalidate request; restarts the clear sweep.
u_correct_o  out  bpu_correct_t  registered packet to PC-gen correction port.
init_we_o  out  1  clear-sweep write strobe.
init_addr_o  out  INIT_AW  clear-sweep table index.
busy_o  out  1  high while in S_INIT.

Behaviour:
- Reset (async, rst_n=0):
  - state=S_INIT, sweep pointer=0, FIFO empty.
  - u_correct_o=all-zero; init_we_o=0; init_addr_o=0; busy_o=1.
- Packet classes:
  - urgent = valid & (redirect | miss | ras_miss_type).
  - train = valid & need_update & !urgent.
  - Any other valid packet is ignored.
- Urgent path:
  - Lane 0 wins. If lane 0 is urgent, lane 1 is discarded whatever its class (it is younger than the redirect).
  - If only lane 1 is urgent, lane 0 is still classified normally (train may enqueue).
  - The urgent packet is loaded into u_correct_o at the next edge: latency 1 cycle.
  - Urgent packets are accepted in every state. In S_INIT they are issued with need_update forced 0.
- Training FIFO:
  - Enqueue order: lane 0 then lane 1.
  - Free space is computed from the pre-edge count; a same-cycle dequeue is not credited.
  - If free < number of train packets, enqueue the older ones and drop the remainder. No backpressure upstream.
  - Pointers are log2(DEPTH) bits plus one wrap bit: full = MSBs differ and low bits equal.
- Issue (registered, one packet per cycle):
  - Urgent input has priority.
  - Otherwise, in S_RUN and FIFO non-empty, the head is dequeued into u_correct_o.
  - Otherwise u_correct_o is zero.
  - Earliest issue of an enqueued packet: the edge after its enqueue edge.
- FSM:
  - S_INIT: init_we_o=1, init_addr_o=pointer, pointer+1 each cycle. At pointer==INIT_DEPTH-1, go to S_RUN next edge; busy_o drops with the state.
  - S_RUN: drain FIFO.
  - flush_i in S_RUN: FIFO cleared; state=S_INIT, pointer=0 at next edge.
  - flush_i in S_INIT: pointer restarts at 0.
  - flush_i together with a train packet: the train packet is dropped.
  - flush_i together with an urgent packet: the urgent packet is still issued, need_update=0.
- Training entries queued during S_INIT are held and drained once in S_RUN.
- Reset mid-sweep or mid-drain: everything returns to reset values immediately.

Optional Feature:
WIRED_BPU_UPD_PERF_EN
- Defined: adds outputs perf_issue_o[31:0] (packets issued with need_update=1) and perf_drop_o[31:0] (train packets dropped for FIFO full or flush).
  - Both are async-cleared by rst_n, cleared by flush_i, and wrap modulo 2^32.
- Undefined: ports and counters are absent; functional behaviour is identical.

Test Plan:
- Reset release, no input -> busy_o=1 for 512 cycles, init_addr_o 0..511, init_we_o=1 throughout; then busy_o=0 and u_correct_o=0.
- S_RUN, lane0 train(pc=0x1c000010) and lane1 train(pc=0x1c000018) same cycle -> issued on two consecutive cycles, 0x10 first, starting 2 edges after input.
- FIFO holding 3 entries, lane0 urgent redirect(true_target=0x1c000100) and lane1 train -> u_correct_o.redirect=1 next edge with target 0x1c000100; lane1 discarded; FIFO drain resumes afterward, count 3.
- FIFO holding 3 entries (DEPTH=4), two train packets arrive -> lane0 enqueued, lane1 dropped, perf_drop_o=1 (with PERF_EN).
- flush_i in S_RUN with 2 queued entries -> FIFO empty, busy_o=1 next cycle, init_addr_o restarts at 0, no queued packet issued.
- Urgent miss during S_INIT at pointer 100 -> issued next edge with need_update=0; sweep continues to 101 uninterrupted.

Source files
------------

// File: rtl/wired_bpu_upd_sched.sv
// wired_bpu_upd_sched: merges the two commit-lane correction packets into
// one registered update stream toward the PC-gen predictor correction port.
// Urgent packets (redirect/miss/RAS miss) bypass a small training FIFO.
// After reset or a flush, a clear sequencer sweeps the predictor tables
// before any training update is released.
// Optional feature macro: WIRED_BPU_UPD_PERF_EN (issue/drop counters).

package wired_bpu_pkg;
    typedef struct packed {
        logic        need_update;
        logic        redirect;
        logic        miss;
        logic        ras_miss_type;
        logic        taken;
        logic [31:0] pc;
        logic [31:0] true_target;
    } bpu_correct_t;
endpackage

module wired_bpu_upd_sched
    import wired_bpu_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int INIT_DEPTH = 512,
    parameter int INIT_AW    = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              c_valid_i,
    input  bpu_correct_t [1:0]      c_correct_i,
    input  logic                    flush_i,
    output bpu_correct_t            u_correct_o,
    output logic                    init_we_o,
    output logic [INIT_AW-1:0]      init_addr_o,
    output logic                    busy_o
`ifdef WIRED_BPU_UPD_PERF_EN
    ,
    output logic [31:0]             perf_issue_o,
    output logic [31:0]             perf_drop_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);
    localparam logic [INIT_AW-1:0] PTR_LAST = INIT_AW'(INIT_DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [INIT_AW-1:0] ptr_q, ptr_d;

    bpu_correct_t       mem [DEPTH];
    logic [PW:0]        wr_q, rd_q;
    logic [PW:0]        count, free;
    logic               empty;

    logic               urg0, urg1, any_urg;
    logic               tr0, tr1;
    logic               enq0, enq1, deq;
    logic [PW-1:0]      wr_idx0, wr_idx1;

    bpu_correct_t       u_d;

    // Classify each lane; an urgent lane 0 squashes whatever lane 1 carries.
    always_comb begin
        urg0 = c_valid_i[0] & (c_correct_i[0].redirect | c_correct_i[0].miss
                               | c_correct_i[0].ras_miss_type);
        urg1 = c_valid_i[1] & (c_correct_i[1].redirect | c_correct_i[1].miss
                               | c_correct_i[1].ras_miss_type) & ~urg0;
        any_urg = urg0 | urg1;
        tr0 = c_valid_i[0] & c_correct_i[0].need_update & ~urg0;
        tr1 = c_valid_i[1] & c_correct_i[1].need_update & ~urg1 & ~urg0;
    end

    // FIFO occupancy and enqueue decisions; free space ignores a same-cycle pop.
    always_comb begin
        count   = wr_q - rd_q;
        empty   = (count == '0);
        free    = DEPTH_W - count;
        enq0    = tr0 & ~flush_i & (free != '0);
        enq1    = tr1 & ~flush_i & (free > (PW+1)'(enq0));
        wr_idx0 = wr_q[PW-1:0];
        wr_idx1 = wr_q[PW-1:0] + PW'(enq0);
    end

    // Pick the packet to issue next: urgent first, else the FIFO head in S_RUN.
    always_comb begin
        u_d = '0;
        deq = 1'b0;
        if (any_urg) begin
            u_d = urg0 ? c_correct_i[0] : c_correct_i[1];
            if (state_q == S_INIT || flush_i) begin
                u_d.need_update = 1'b0;
            end
        end else if (state_q == S_RUN && !flush_i && !empty) begin
            u_d = mem[rd_q[PW-1:0]];
            deq = 1'b1;
        end
    end

    // Clear-sweep sequencing; a flush always restarts the sweep from index 0.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (flush_i) begin
            state_d = S_INIT;
            ptr_d   = '0;
        end else if (state_q == S_INIT) begin
            if (ptr_q == PTR_LAST) begin
                state_d = S_RUN;
                ptr_d   = '0;
            end else begin
                ptr_d = ptr_q + INIT_AW'(1);
            end
        end
    end

    // State, sweep pointer and registered output packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            ptr_q       <= '0;
            u_correct_o <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            u_correct_o <= u_d;
        end
    end

    // FIFO pointers; a flush discards every queued training entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + (PW+1)'(enq0) + (PW+1)'(enq1);
            rd_q <= rd_q + (PW+1)'(deq);
        end
    end

    // FIFO storage needs no reset: the pointers alone define valid entries.
    always_ff @(posedge clk) begin
        if (enq0) mem[wr_idx0] <= c_correct_i[0];
        if (enq1) mem[wr_idx1] <= c_correct_i[1];
    end

    assign busy_o      = (state_q == S_INIT);
    assign init_we_o   = busy_o & rst_n;
    assign init_addr_o = ptr_q;

`ifdef WIRED_BPU_UPD_PERF_EN
    logic [1:0] n_train, n_enq;
    assign n_train = 2'(tr0) + 2'(tr1);
    assign n_enq   = 2'(enq0) + 2'(enq1);

    // Count issued training updates and training packets lost to a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_o <= '0;
            perf_drop_o  <= '0;
        end else if (flush_i) begin
            perf_issue_o <= '0;
            perf_drop_o  <= '0;
        end else begin
            perf_issue_o <= perf_issue_o + 32'(u_d.need_update);
            perf_drop_o  <= perf_drop_o + 32'(n_train - n_enq);
        end
    end
`endif

endmodule

// File: tb/tb_wired_bpu_upd_sched.sv
// Self-checking bench for wired_bpu_upd_sched: directed scenarios with
// literal expectations plus randomized traffic against a queue-based model.
module tb_wired_bpu_upd_sched;
    import wired_bpu_pkg::*;

    localparam int DEPTH      = 4;
    localparam int INIT_DEPTH = 512;
    localparam int INIT_AW    = 9;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [1:0]         c_valid = '0;
    bpu_correct_t [1:0] c_correct = '0;
    logic               flush = 1'b0;
    bpu_correct_t       u_correct;
    logic               init_we;
    logic [INIT_AW-1:0] init_addr;
    logic               busy;
`ifdef WIRED_BPU_UPD_PERF_EN
    logic [31:0]        perf_issue, perf_drop;
    int unsigned        m_issue, m_drop;
`endif

    wired_bpu_upd_sched #(.DEPTH(DEPTH), .INIT_DEPTH(INIT_DEPTH), .INIT_AW(INIT_AW)) dut (
        .clk(clk), .rst_n(rst_n), .c_valid_i(c_valid), .c_correct_i(c_correct),
        .flush_i(flush), .u_correct_o(u_correct), .init_we_o(init_we),
        .init_addr_o(init_addr), .busy_o(busy)
`ifdef WIRED_BPU_UPD_PERF_EN
        , .perf_issue_o(perf_issue), .perf_drop_o(perf_drop)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue, a busy flag and a sweep index.
    bpu_correct_t mq[$];
    bit           m_busy;
    int           m_ptr;
    bpu_correct_t m_u;
    int           n_cmp = 0;
    int           n_fail = 0;

    function automatic bpu_correct_t mk(bit need, bit redir, bit miss, bit ras,
                                        logic [31:0] pc, logic [31:0] tgt);
        bpu_correct_t p;
        p = '0;
        p.need_update   = need;
        p.redirect      = redir;
        p.miss          = miss;
        p.ras_miss_type = ras;
        p.pc            = pc;
        p.true_target   = tgt;
        return p;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_busy = 1'b1;
        m_ptr  = 0;
        m_u    = '0;
`ifdef WIRED_BPU_UPD_PERF_EN
        m_issue = 0;
        m_drop  = 0;
`endif
    endtask

    // One clock edge of the specified behaviour.
    task automatic model_step(input logic [1:0] v, input bpu_correct_t c0,
                              input bpu_correct_t c1, input bit fl);
        bit u0, u1, t0, t1;
        int pre, free, ntr, nenq;
        bpu_correct_t pkt;
        pkt = '0;
        u0 = v[0] && (c0.redirect || c0.miss || c0.ras_miss_type);
        u1 = v[1] && (c1.redirect || c1.miss || c1.ras_miss_type);
        t0 = v[0] && c0.need_update && !u0;
        t1 = v[1] && c1.need_update && !u1 && !u0;
        pre = mq.size();
        if (u0) pkt = c0;
        else if (u1) pkt = c1;
        if (u0 || u1) begin
            if (m_busy || fl) pkt.need_update = 1'b0;
        end else if (!m_busy && !fl && pre > 0) begin
            pkt = mq.pop_front();
        end
        ntr = int'(t0) + int'(t1);
        nenq = 0;
        if (fl) mq.delete();
        else begin
            free = DEPTH - pre;
            if (t0 && free > 0) begin mq.push_back(c0); free--; nenq++; end
            if (t1 && free > 0) begin mq.push_back(c1); nenq++; end
        end
        if (fl) begin
            m_busy = 1'b1;
            m_ptr  = 0;
        end else if (m_busy) begin
            if (m_ptr == INIT_DEPTH - 1) begin m_busy = 1'b0; m_ptr = 0; end
            else m_ptr++;
        end
        m_u = pkt;
`ifdef WIRED_BPU_UPD_PERF_EN
        if (fl) begin m_issue = 0; m_drop = 0; end
        else begin
            m_issue += int'(pkt.need_update);
            m_drop  += ntr - nenq;
        end
`endif
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic checkOutput();
        n_cmp++;
        if (u_correct !== m_u) begin
            n_fail++;
            $display("[TB] FAIL u_correct: got %h expected %h at %0t", u_correct, m_u, $time);
        end
        cmp("busy", 32'(busy), 32'(m_busy));
        cmp("init_we", 32'(init_we), 32'(m_busy));
        cmp("init_addr", 32'(init_addr), m_ptr);
`ifdef WIRED_BPU_UPD_PERF_EN
        cmp("perf_issue", perf_issue, m_issue);
        cmp("perf_drop", perf_drop, m_drop);
`endif
    endtask

    // Drive one cycle of inputs, advance the model, check on the falling edge.
    task automatic applyStimulus(input logic [1:0] v, input bpu_correct_t c0,
                                 input bpu_correct_t c1, input bit fl);
        c_valid      = v;
        c_correct[0] = c0;
        c_correct[1] = c1;
        flush        = fl;
        model_step(v, c0, c1, fl);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(2'b00, '0, '0, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n   = 1'b0;
        c_valid = '0;
        flush   = 1'b0;
        #1;
        model_reset();
        cmp("rst_u_zero", 32'(|u_correct), 32'd0);
        cmp("rst_we", 32'(init_we), 32'd0);
        cmp("rst_addr", 32'(init_addr), 32'd0);
        cmp("rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cmp("rel_we", 32'(init_we), 32'd1);
    endtask

    function automatic bpu_correct_t rnd_pkt();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) begin
            int k;
            k = $urandom_range(0, 2);
            return mk(1'($urandom), k == 0, k == 1, k == 2, $urandom, $urandom);
        end else if (r < 7) return mk(1'b1, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
        else return mk(1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
    endfunction

    initial begin
        bpu_correct_t tA;
        model_reset();
        repeat (2) @(negedge clk);
        doReset();

        // Full sweep with no traffic.
        idle(511);
        cmp("sweep_addr_511", 32'(init_addr), 32'd511);
        cmp("sweep_busy_511", 32'(busy), 32'd1);
        idle(1);
        cmp("sweep_done_busy", 32'(busy), 32'd0);
        cmp("sweep_done_u", 32'(|u_correct), 32'd0);

        // Two training packets in one cycle drain in lane order.
        applyStimulus(2'b11, mk(1, 0, 0, 0, 32'h1c000010, 0), mk(1, 0, 0, 0, 32'h1c000018, 0), 0);
        cmp("tr_edge1_zero", 32'(|u_correct), 32'd0);
        idle(1);
        cmp("tr_first_pc", u_correct.pc, 32'h1c000010);
        idle(1);
        cmp("tr_second_pc", u_correct.pc, 32'h1c000018);
        idle(1);

        // Urgent redirect overtakes a 3-deep FIFO and squashes lane 1.
        applyStimulus(2'b11, mk(1, 0, 0, 0, 32'hA0, 0), mk(1, 0, 0, 0, 32'hB0, 0), 0);
        applyStimulus(2'b11, mk(1, 0, 0, 0, 32'hC0, 0), mk(1, 0, 0, 0, 32'hD0, 0), 0);
        cmp("model_q3", mq.size(), 32'd3);
        applyStimulus(2'b11, mk(1, 1, 0, 0, 32'hE0, 32'h1c000100), mk(1, 0, 0, 0, 32'hF0, 0), 0);
        cmp("urg_redirect", 32'(u_correct.redirect), 32'd1);
        cmp("urg_target", u_correct.true_target, 32'h1c000100);
        idle(1);
        cmp("drain_b", u_correct.pc, 32'hB0);
        idle(1);
        cmp("drain_c", u_correct.pc, 32'hC0);
        idle(1);
        cmp("drain_d", u_correct.pc, 32'hD0);
        idle(1);
        cmp("drain_end", 32'(|u_correct), 32'd0);

        // FIFO at 3 entries: only the older of two new training packets fits.
        applyStimulus(2'b11, mk(1, 0, 0, 0, 32'h100, 0), mk(1, 0, 0, 0, 32'h104, 0), 0);
        applyStimulus(2'b11, mk(1, 0, 0, 0, 32'h108, 0), mk(1, 0, 0, 0, 32'h10c, 0), 0);
        applyStimulus(2'b11, mk(1, 0, 0, 0, 32'h110, 0), mk(1, 0, 0, 0, 32'h114, 0), 0);
        cmp("model_full_q3", mq.size(), 32'd3);
        idle(3);
        cmp("full_last_pc", u_correct.pc, 32'h110);

        // Flush with two queued entries: sweep restarts, queue discarded.
        applyStimulus(2'b11, mk(1, 0, 0, 0, 32'h200, 0), mk(1, 0, 0, 0, 32'h204, 0), 0);
        applyStimulus(2'b00, '0, '0, 1);
        cmp("flush_busy", 32'(busy), 32'd1);
        cmp("flush_addr", 32'(init_addr), 32'd0);
        cmp("flush_u", 32'(|u_correct), 32'd0);

        // Urgent miss in the middle of the sweep.
        idle(100);
        cmp("mid_addr", 32'(init_addr), 32'd100);
        applyStimulus(2'b01, mk(1, 0, 1, 0, 32'h300, 32'h304), '0, 0);
        cmp("mid_miss", 32'(u_correct.miss), 32'd1);
        cmp("mid_need", 32'(u_correct.need_update), 32'd0);
        cmp("mid_addr_next", 32'(init_addr), 32'd101);

        // Randomized traffic with rare flushes and one asynchronous reset.
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                doReset();
            end else begin
                tA = rnd_pkt();
                applyStimulus(2'($urandom), tA, rnd_pkt(), $urandom_range(0, 399) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
